bch_64_chk: RTL and testbench

Pipelined-handshake checker for the BCH(78,64) codeword, placed directly downstream of the 64-bit BCH encoder (or at the far end of the channel it feeds). It accepts one 78-bit codeword per transaction and recomputes the parity by serial division over `W` bits per cycle. It outputs the 14-bit syndrome, an error flag and the 64 data bits. No correction is performed here; a non-zero syndrome goes to the downstream corrector or error handler.

---
 rtl/bch_64_chk.sv | 157 +++++++++++++++
 tb/tb_bch_64_chk.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_64_chk.sv
// BCH(78,64) syndrome checker: serial parity recomputation, W data bits per cycle.
// Optional saturating error counter enabled by defining BCH64_CHK_ERRCNT_EN.
module bch_64_chk #(
    parameter int unsigned W        = 4,
    parameter logic [14:0] GEN_POLY = 15'h4DB5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:77] in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:13] o_syndrome,
    output logic        o_err,
    output logic [0:63] o_data
`ifdef BCH64_CHK_ERRCNT_EN
    ,
    input  logic        err_cnt_clr,
    output logic [15:0] o_err_cnt
`endif
);

    localparam int unsigned BEATS = 64 / W;
    localparam int unsigned CW    = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [0:63]   shreg_q, shreg_d;
    logic [0:13]   par_q, par_d;
    logic [13:0]   lfsr_q, lfsr_d;
    logic          out_valid_q, out_valid_d;
    logic [0:13]   syn_q, syn_d;
    logic          err_q, err_d;
    logic [0:63]   data_q, data_d;

    logic [13:0]   lfsr_step;
    logic [0:63]   shreg_rot;
    logic [0:13]   syn_next;
    logic          fb;

    always_comb begin
        fb        = 1'b0;
        lfsr_step = lfsr_q;
        for (int unsigned j = 0; j < W; j++) begin
            fb        = shreg_q[j] ^ lfsr_step[13];
            lfsr_step = {lfsr_step[12:0], 1'b0} ^ (fb ? GEN_POLY[13:0] : 14'h0);
        end
        // Rotating rather than shifting leaves the original data in place after the last beat.
        shreg_rot = {shreg_q[W:63], shreg_q[0:W-1]};
        // Positional XOR pairs lfsr_step[13-p] with par_q[p].
        syn_next  = lfsr_step ^ par_q;
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        lfsr_d      = lfsr_q;
        out_valid_d = out_valid_q;
        syn_d       = syn_q;
        err_d       = err_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shreg_d = in_code[14:77];
                    par_d   = in_code[0:13];
                    lfsr_d  = '0;
                    beat_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = shreg_rot;
                lfsr_d  = lfsr_step;
                beat_d  = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    syn_d       = syn_next;
                    err_d       = |syn_next;
                    data_d      = shreg_rot;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            beat_q      <= '0;
            shreg_q     <= '0;
            par_q       <= '0;
            lfsr_q      <= '0;
            out_valid_q <= 1'b0;
            syn_q       <= '0;
            err_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            beat_q      <= beat_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            syn_q       <= syn_d;
            err_q       <= err_d;
            data_q      <= data_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign o_syndrome = syn_q;
    assign o_err      = err_q;
    assign o_data     = data_q;

`ifdef BCH64_CHK_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (out_valid_q && out_ready && err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_bch_64_chk.sv
// Scoreboard bench for bch_64_chk: three instances (W=1,4,16) fed identical directed words plus
// random words, checked against a polynomial-remainder model built from x^k mod g(x).
module tb_bch_64_chk;

    localparam logic [14:0] G = 15'h4DB5;

    typedef struct {
        logic [0:13] syn;
        logic [0:63] data;
        int unsigned acc;
        int          idx;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned cycle = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic chk(input int unsigned w, input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL W=%0d %s: got %0h expected %0h", w, nm, act, exp_v);
        end
    endtask

    // Coefficient of x^k: parity p carries degree 13-p, data bit i (in_code[14+i]) degree 77-i.
    function automatic logic coef(input logic [0:77] c, input int k);
        return (k < 14) ? c[13-k] : c[91-k];
    endfunction

    function automatic logic [13:0] mulx(input logic [13:0] p);
        return {p[12:0], 1'b0} ^ (p[13] ? G[13:0] : 14'h0);
    endfunction

    // c(x) mod g(x); bit d of the result is the coefficient of x^d.
    function automatic logic [13:0] ref_rem(input logic [0:77] c);
        logic [13:0] pw;
        logic [13:0] acc;
        pw  = 14'h1;
        acc = '0;
        for (int k = 0; k < 78; k++) begin
            if (coef(c, k)) acc ^= pw;
            pw = mulx(pw);
        end
        return acc;
    endfunction

    function automatic logic [0:77] make_valid(input logic [0:63] d);
        logic [0:77] w;
        logic [13:0] r;
        w        = '0;
        w[14:77] = d;
        r        = ref_rem(w);
        w[0:13]  = r;
        return w;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int unsigned WG = (g == 0) ? 1 : (g == 1) ? 4 : 16;
        localparam int unsigned NB = 64 / WG;

        logic        reset_n, in_valid, in_ready, out_valid, out_ready, o_err;
        logic [0:77] in_code;
        logic [0:13] o_syndrome;
        logic [0:63] o_data;
`ifdef BCH64_CHK_ERRCNT_EN
        logic        err_cnt_clr;
        logic [15:0] o_err_cnt;
`endif
        exp_t        q[$];
        int unsigned last_hs = 0;
        bit          drv_done = 1'b0;

        bch_64_chk #(.W(WG), .GEN_POLY(15'h4DB5)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_code    (in_code),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .o_syndrome (o_syndrome),
            .o_err      (o_err),
            .o_data     (o_data)
`ifdef BCH64_CHK_ERRCNT_EN
            ,
            .err_cnt_clr(err_cnt_clr),
            .o_err_cnt  (o_err_cnt)
`endif
        );

        task automatic send(input logic [0:77] w, input int idx, input bit push);
            int unsigned waited;
            logic [95:0] junk;
            exp_t        e;
            waited = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_code  = w;
            while (!in_ready && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                chk(WG, "accept timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            if (push) begin
                e.syn  = ref_rem(w);
                e.data = w[14:77];
                e.acc  = cycle + 1;
                e.idx  = idx;
                q.push_back(e);
                if (idx > 0) chk(WG, "accept edge after handshake", 64'(cycle + 1), 64'(last_hs + 1));
            end
            @(posedge clk);
            #1;
            junk     = {$urandom(), $urandom(), $urandom()};
            in_valid = 1'b0;
            in_code  = junk[77:0];
        endtask

        initial begin : driver
            logic [0:77] w;
            logic [63:0] rd;
            reset_n  = 1'b0;
            in_valid = 1'b0;
            in_code  = '0;
            repeat (3) @(negedge clk);
            chk(WG, "reset in_ready", 64'(in_ready), 64'd0);
            chk(WG, "reset out_valid", 64'(out_valid), 64'd0);
            chk(WG, "reset o_syndrome", 64'(o_syndrome), 64'd0);
            chk(WG, "reset o_err", 64'(o_err), 64'd0);
            chk(WG, "reset o_data", 64'(o_data), 64'd0);
`ifdef BCH64_CHK_ERRCNT_EN
            chk(WG, "reset o_err_cnt", 64'(o_err_cnt), 64'd0);
`endif
            reset_n = 1'b1;
            @(negedge clk);
            chk(WG, "in_ready after release", 64'(in_ready), 64'd1);

            for (int n = 0; n < 15; n++) begin
                w = '0;
                case (n)
                    0: ;
                    1, 2: begin
                        w[77] = (n == 1);
                        w[2] = 1'b1; w[3] = 1'b1; w[5] = 1'b1; w[6] = 1'b1;
                        w[8] = 1'b1; w[9] = 1'b1; w[11] = 1'b1; w[13] = 1'b1;
                    end
                    3: w[13] = 1'b1;
                    4: w[0] = 1'b1;
                    default: begin
                        rd = {$urandom(), $urandom()};
                        w  = make_valid(rd);
                        if (n == 5 || $urandom_range(0, 1) == 1) begin
                            int k;
                            k    = int'($urandom_range(0, 77));
                            w[k] = ~w[k];
                        end
                    end
                endcase
                send(w, n, 1'b1);
            end

            for (int t = 0; t < 3000 && (q.size() != 0 || out_valid); t++) @(negedge clk);
            chk(WG, "scoreboard drained", 64'(q.size()), 64'd0);

            rd = {$urandom(), $urandom()};
            send(make_valid(rd), -1, 1'b0);
            repeat (NB / 2) @(negedge clk);
            reset_n = 1'b0;
            #1;
            chk(WG, "abort out_valid", 64'(out_valid), 64'd0);
            chk(WG, "abort in_ready", 64'(in_ready), 64'd0);
`ifdef BCH64_CHK_ERRCNT_EN
            chk(WG, "abort o_err_cnt", 64'(o_err_cnt), 64'd0);
`endif
            @(negedge clk);
            reset_n = 1'b1;
            repeat (NB + 4) @(negedge clk);
            chk(WG, "no output after abort", 64'(out_valid), 64'd0);
            drv_done = 1'b1;
        end

        initial begin : monitor
            logic [0:13] hold_syn;
            logic [0:63] hold_data;
            int          hold;
            bit          seen;
            exp_t        e;
            int unsigned cnt_m;
            out_ready = 1'b1;
`ifdef BCH64_CHK_ERRCNT_EN
            err_cnt_clr = 1'b0;
`endif
            seen  = 1'b0;
            hold  = 0;
            cnt_m = 0;
            e.idx = -1;
            forever begin
                @(negedge clk);
                #2;
                if (!reset_n) begin
                    cnt_m     = 0;
                    seen      = 1'b0;
                    out_ready = 1'b1;
`ifdef BCH64_CHK_ERRCNT_EN
                    err_cnt_clr = 1'b0;
`endif
                    continue;
                end
`ifdef BCH64_CHK_ERRCNT_EN
                chk(WG, "o_err_cnt", 64'(o_err_cnt), 64'(cnt_m));
                err_cnt_clr = 1'b0;
`endif
                if (out_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (q.size() == 0) begin
                            e.idx = -1;
                            chk(WG, "unexpected out_valid", 64'(out_valid), 64'd0);
                        end else begin
                            e = q[0];
                            chk(WG, $sformatf("o_syndrome word%0d", e.idx), 64'(o_syndrome), 64'(e.syn));
                            chk(WG, $sformatf("o_err word%0d", e.idx), 64'(o_err), 64'(|e.syn));
                            chk(WG, $sformatf("o_data word%0d", e.idx), 64'(o_data), 64'(e.data));
                            chk(WG, $sformatf("latency word%0d", e.idx), 64'(cycle - e.acc), 64'(NB));
                        end
                        hold_syn  = o_syndrome;
                        hold_data = o_data;
                        hold      = (e.idx == 1) ? 5 : (e.idx < 5) ? 0 : int'($urandom_range(0, 3));
                    end else begin
                        chk(WG, "held o_syndrome", 64'(o_syndrome), 64'(hold_syn));
                        chk(WG, "held o_data", 64'(o_data), 64'(hold_data));
                        chk(WG, "in_ready in DONE", 64'(in_ready), 64'd0);
                        if (hold > 0) hold--;
                    end
                    out_ready = (hold == 0);
                    if (out_ready) begin
                        last_hs = cycle + 1;
                        seen    = 1'b0;
                        if (e.idx >= 0) begin
                            void'(q.pop_front());
`ifdef BCH64_CHK_ERRCNT_EN
                            err_cnt_clr = (e.idx == 5);
                            if (err_cnt_clr) cnt_m = 0;
                            else if (|e.syn && cnt_m != 32'hFFFF) cnt_m++;
`endif
                        end
                    end
                end else begin
                    out_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        for (int t = 0; t < 60000 && !(u[0].drv_done && u[1].drv_done && u[2].drv_done); t++)
            @(posedge clk);
        chk(0, "bench completion", 64'(u[0].drv_done && u[1].drv_done && u[2].drv_done), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
